// File: rtl/detect_log_pkg.sv
// Shared defaults and helpers for the detection event logger.
package detect_log_pkg;
  localparam int TS_WIDTH_DEF  = 16;
  localparam int DEPTH_DEF     = 4;
  localparam int CNT_WIDTH_DEF = 8;

  // Increment v, holding at the all-ones value of a w-bit counter (w in 1..32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = 32'hFFFF_FFFF >> (32 - w);
    return (v == max_v) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/event_fifo.sv
// Timestamp FIFO: storage, wrap-bit pointers, full/empty and level.
module event_fifo
  import detect_log_pkg::*;
#(
  parameter int WIDTH = TS_WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  // Head is read combinationally; forced to zero when nothing is buffered.
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // When full, push and pop address the same slot; the pop reads it before the edge.
  always_ff @(posedge CLK) begin
    if (push && !clr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end
endmodule

// File: rtl/detect_event_logger.sv
// Timestamps rising edges of detect_in into a FIFO with saturating event/drop counters.
module detect_event_logger
  import detect_log_pkg::*;
#(
  parameter int TS_WIDTH  = TS_WIDTH_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   detect_in,
  input  logic                   clr,
  input  logic                   rd_ready,
  output logic                   rd_valid,
  output logic [TS_WIDTH-1:0]    rd_data,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [CNT_WIDTH-1:0]   event_count,
  output logic [CNT_WIDTH-1:0]   drop_count,
  output logic                   overflow
);
  logic [TS_WIDTH-1:0] ts;
  logic                detect_q;
  logic                evt, push, pop, drop, full, empty;

  assign evt      = detect_in && !detect_q && !clr;
  assign rd_valid = !empty;
  assign pop      = rd_valid && rd_ready && !clr;
  assign push     = evt && (!full || pop);
  assign drop     = evt && full && !pop;

  event_fifo #(.WIDTH(TS_WIDTH), .DEPTH(DEPTH)) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .clr     (clr),
    .push    (push),
    .pop     (pop),
    .wr_data (ts),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .level   (fifo_level)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ts       <= '0;
      detect_q <= 1'b0;
    end else begin
      ts       <= ts + 1'b1;
      detect_q <= detect_in;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      event_count <= '0;
      drop_count  <= '0;
      overflow    <= 1'b0;
    end else if (clr) begin
      event_count <= '0;
      drop_count  <= '0;
      overflow    <= 1'b0;
    end else begin
      if (evt)  event_count <= CNT_WIDTH'(sat_inc(32'(event_count), CNT_WIDTH));
      if (drop) begin
        drop_count <= CNT_WIDTH'(sat_inc(32'(drop_count), CNT_WIDTH));
        overflow   <= 1'b1;
      end
    end
  end
endmodule
